// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 4-word lines.
// Misses refill one word at a time from the memory controller.
module instruction_cache #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFIC_en,
  input  logic [ADDR_WIDTH-1:0] IFIC_pc,
  output logic                  ICIF_en,
  output logic [31:0]           ICIF_data,
  input  logic                  ROBIC_clear,
  output logic                  ICMC_en,
  output logic [ADDR_WIDTH-1:0] ICMC_addr,
  input  logic                  MCIC_en,
  input  logic [31:0]           MCIC_data
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - 4 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  gap_q;
  logic                  gap_d;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;
  logic                  resp_en_d;
  logic [31:0]           resp_data_d;
  logic                  mem_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic [31:0]           data_mem [LINES][4];

  logic [INDEX_BITS-1:0] pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [1:0]            pc_word;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  lookup;
  logic                  fill_beat;
  logic                  last_beat;
  logic                  unused_pc;

  assign pc_idx    = IFIC_pc[4+INDEX_BITS-1:4];
  assign pc_tag    = IFIC_pc[ADDR_WIDTH-1:4+INDEX_BITS];
  assign pc_word   = IFIC_pc[3:2];
  assign unused_pc = ^IFIC_pc[1:0];

  // The line under refill is named by the request address
  assign fill_idx  = ICMC_addr[4+INDEX_BITS-1:4];
  assign fill_tag  = ICMC_addr[ADDR_WIDTH-1:4+INDEX_BITS];

  assign hit = valid_q[pc_idx] &&
               (tag_mem[pc_idx] == pc_tag);

  assign lookup = Sys_rdy && (state_q == IDLE) &&
                  IFIC_en && !gap_q && !ROBIC_clear;

  assign fill_beat = Sys_rdy && (state_q == REFILL) &&
                     MCIC_en;
  assign last_beat = fill_beat && (cnt_q == 2'd3);

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    resp_en_d   = ICIF_en;
    resp_data_d = ICIF_data;
    mem_en_d    = ICMC_en;
    mem_addr_d  = ICMC_addr;
    if (Sys_rdy) begin
      resp_en_d = 1'b0;
      gap_d     = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lookup && hit) begin
            resp_en_d   = 1'b1;
            resp_data_d = data_mem[pc_idx][pc_word];
            gap_d       = 1'b1;
          end else if (lookup) begin
            state_d    = REFILL;
            cnt_d      = 2'd0;
            mem_en_d   = 1'b1;
            mem_addr_d = {IFIC_pc[ADDR_WIDTH-1:4], 4'b0};
          end
        end
        REFILL: begin
          if (MCIC_en) begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              mem_en_d = 1'b0;
              state_d  = IDLE;
            end else begin
              mem_addr_d = ICMC_addr + ADDR_WIDTH'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control state and output registers
  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      state_q   <= IDLE;
      gap_q     <= 1'b0;
      cnt_q     <= 2'd0;
      ICIF_en   <= 1'b0;
      ICIF_data <= 32'd0;
      ICMC_en   <= 1'b0;
      ICMC_addr <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      ICIF_en   <= resp_en_d;
      ICIF_data <= resp_data_d;
      ICMC_en   <= mem_en_d;
      ICMC_addr <= mem_addr_d;
    end
  end

  // Valid bits: dropped at miss so a partial line is never served
  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      valid_q <= '0;
    end else begin
      if (lookup && !hit) begin
        valid_q[pc_idx] <= 1'b0;
      end
      if (last_beat) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays, written only by refill beats
  always_ff @(posedge Sys_clk) begin
    if (fill_beat) begin
      data_mem[fill_idx][cnt_q] <= MCIC_data;
    end
    if (last_beat) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised scoreboard bench for instruction_cache with a
// behavioural memory and a tag-map reference model.
module tb_instruction_cache;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst;
  logic        Sys_rdy;
  logic        IFIC_en;
  logic [31:0] IFIC_pc;
  logic        ICIF_en;
  logic [31:0] ICIF_data;
  logic        ROBIC_clear;
  logic        ICMC_en;
  logic [31:0] ICMC_addr;
  logic        MCIC_en;
  logic [31:0] MCIC_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q  [$];
  logic [31:0] addr_q [$];
  int lat_lo = 2;
  int lat_hi = 2;

  bit          m_val [int];
  logic [19:0] m_tag [int];

  instruction_cache dut (
    .Sys_clk    (Sys_clk),
    .Sys_rst    (Sys_rst),
    .Sys_rdy    (Sys_rdy),
    .IFIC_en    (IFIC_en),
    .IFIC_pc    (IFIC_pc),
    .ICIF_en    (ICIF_en),
    .ICIF_data  (ICIF_data),
    .ROBIC_clear(ROBIC_clear),
    .ICMC_en    (ICMC_en),
    .ICMC_addr  (ICMC_addr),
    .MCIC_en    (MCIC_en),
    .MCIC_data  (MCIC_data)
  );

  always #5 Sys_clk = ~Sys_clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:2], 2'b01, ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // A miss installs the line (the refill always completes)
  function automatic bit model_hit(input logic [31:0] pc);
    int i;
    i = int'(pc[11:4]);
    if (m_val.exists(i) && m_val[i] && m_tag[i] == pc[31:12])
      return 1'b1;
    m_val[i] = 1'b1;
    m_tag[i] = pc[31:12];
    return 1'b0;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge Sys_clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] pc,
                       input bit want_resp,
                       output bit hit);
    hit = model_hit(pc);
    if (!hit)
      for (int k = 0; k < 4; k++)
        addr_q.push_back({pc[31:4], 4'b0} + 32'(4 * k));
    if (want_resp)
      exp_q.push_back(memw({pc[31:2], 2'b00}));
    IFIC_pc = pc;
    IFIC_en = 1'b1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!ICIF_en && n < 400);
    if (!ICIF_en)
      chk("resp_timeout", 32'(n), 32'd0);
    IFIC_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, output int n);
    bit hit;
    step(1);
    issue(pc, 1'b1, hit);
    wait_resp(n);
    if (hit)
      chk("hit_lat", 32'(n), 32'd1);
    else
      chk("miss_lat_min", 32'(n >= 6), 32'd1);
  endtask

  // Memory controller: one word per request after a random delay
  initial begin : memproc
    int  wait_c;
    bit  busy;
    busy    = 1'b0;
    wait_c  = 0;
    MCIC_en = 1'b0;
    forever begin
      @(negedge Sys_clk);
      MCIC_en = 1'b0;
      if (!Sys_rst) begin
        busy = 1'b0;
        continue;
      end
      if (!Sys_rdy)
        continue;
      if (!busy && ICMC_en) begin
        if (addr_q.size() == 0)
          chk("unexp_memreq", 32'd1, 32'd0);
        else
          chk("mem_addr", ICMC_addr, addr_q.pop_front());
        busy   = 1'b1;
        wait_c = $urandom_range(lat_hi, lat_lo);
      end
      if (busy) begin
        if (wait_c == 0) begin
          MCIC_en   = 1'b1;
          MCIC_data = memw(ICMC_addr);
          busy      = 1'b0;
        end else begin
          wait_c--;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every pulse
  initial begin : monitor
    logic [31:0] last;
    bit          prev;
    last = 32'd0;
    prev = 1'b0;
    forever begin
      @(negedge Sys_clk);
      if (!Sys_rst) begin
        last = 32'd0;
        prev = 1'b0;
        continue;
      end
      if (ICIF_en) begin
        if (prev)
          chk("double_pulse", 32'd1, 32'd0);
        if (exp_q.size() == 0)
          chk("unexp_resp", ICIF_data, 32'hxxxx_xxxx);
        else
          chk("resp_data", ICIF_data, exp_q.pop_front());
        last = ICIF_data;
      end else begin
        chk("data_hold", ICIF_data, last);
      end
      prev = ICIF_en;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          n;
    bit          hit;
    logic [31:0] a;
    logic [31:0] pc;
    Sys_rst     = 1'b0;
    Sys_rdy     = 1'b1;
    IFIC_en     = 1'b0;
    IFIC_pc     = 32'd0;
    ROBIC_clear = 1'b0;
    MCIC_data   = 32'd0;
    step(3);
    chk("rst_icif_en", ICIF_en, 32'd0);
    chk("rst_icif_data", ICIF_data, 32'd0);
    chk("rst_icmc_en", ICMC_en, 32'd0);
    chk("rst_icmc_addr", ICMC_addr, 32'd0);
    Sys_rst = 1'b1;

    fetch(32'h0, n);
    chk("cold_lat", 32'(n), 32'd14);
    chk("cold_mem_idle", ICMC_en, 32'd0);

    fetch(32'h8, n);
    step(3);
    chk("hold_en", ICIF_en, 32'd0);
    chk("hold_data", ICIF_data, memw(32'h8));
    chk("hold_mem_idle", ICMC_en, 32'd0);

    fetch(32'h1000, n);
    chk("conflict_lat", 32'(n), 32'd14);
    fetch(32'h0, n);
    chk("reconflict_lat", 32'(n), 32'd14);

    step(1);
    IFIC_pc     = 32'h4;
    IFIC_en     = 1'b1;
    ROBIC_clear = 1'b1;
    step(1);
    ROBIC_clear = 1'b0;
    IFIC_en     = 1'b0;
    chk("clr_hit_no_resp", ICIF_en, 32'd0);

    step(1);
    issue(32'h20, 1'b0, hit);
    step(2);
    ROBIC_clear = 1'b1;
    issue(32'h40, 1'b1, hit);
    step(1);
    ROBIC_clear = 1'b0;
    wait_resp(n);
    chk("clr_refill_resp", ICIF_en, 32'd1);

    step(1);
    issue(32'h60, 1'b1, hit);
    step(5);
    a       = ICMC_addr;
    Sys_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("frz_addr", ICMC_addr, a);
      chk("frz_mem_en", ICMC_en, 32'd1);
      chk("frz_resp", ICIF_en, 32'd0);
    end
    Sys_rdy = 1'b1;
    wait_resp(n);
    chk("frz_lat", 32'(n), 32'd9);

    step(1);
    issue(32'h80, 1'b0, hit);
    step(3);
    #2;
    Sys_rst = 1'b0;
    #1;
    chk("arst_mem_en", ICMC_en, 32'd0);
    chk("arst_resp", ICIF_en, 32'd0);
    chk("arst_addr", ICMC_addr, 32'd0);
    IFIC_en = 1'b0;
    addr_q.delete();
    exp_q.delete();
    m_val.delete();
    m_tag.delete();
    #20;
    Sys_rst = 1'b1;
    fetch(32'h0, n);
    chk("post_rst_miss_lat", 32'(n), 32'd14);

    lat_lo = 0;
    lat_hi = 3;
    repeat (150) begin
      pc = (32'($urandom_range(0, 2)) << 12) |
           (32'($urandom_range(0, 3)) << 4) |
           (32'($urandom_range(0, 3)) << 2);
      step($urandom_range(0, 2));
      fetch(pc, n);
    end

    step(3);
    chk("resp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
Direct-mapped, read-only instruction cache between the memory controller (upstream) and the instruction fetcher (downstream). It serves the fetcher's level-held request {IFIC_en, IFIC_pc} with a one-cycle-pulsed {ICIF_en, ICIF_data}. On a miss it refills a 4-word line from the memory controller, one word at a time. It also takes a clear from the RoB so that a stale response is not delivered after a misprediction redirect.

Parameters:
ADDR_WIDTH, 32, byte-address width
INDEX_BITS, 8, line-index width (2^INDEX_BITS lines, 16 bytes/line)

Ports:
Sys_clk  in  1  clock, all state on rising edge
Sys_rst  in  1  asynchronous, active-low reset
Sys_rdy  in  1  global enable; low freezes all state and outputs
IFIC_en  in  1  fetch request valid (level, may stay high across many cycles)
IFIC_pc  in  ADDR_WIDTH  fetch byte address; [1:0] ignored
ICIF_en  out  1  response valid, one-cycle pulse
ICIF_data  out  32  instruction word; held stable until the next pulse
ROBIC_clear  in  1  misprediction redirect; asserted in the same cycle the RoB flags a wrong branch to the fetcher
ICMC_en  out  1  memory word request, level-held until accepted
ICMC_addr  out  ADDR_WIDTH  word-aligned request address
MCIC_en  in  1  memory data valid pulse, completes the outstanding request
MCIC_data  in  32  memory word

Behaviour:
- Address split: [3:2] word-in-line; [4+INDEX_BITS-1:4] index; [ADDR_WIDTH-1:4+INDEX_BITS] tag.
- Storage per line: valid bit, tag, 4 x 32-bit words.
- Reset (Sys_rst=0, asynchronous):
  - all valid bits 0; state IDLE; gap flag 0; refill counter 0.
  - ICIF_en=0, ICIF_data=0, ICMC_en=0, ICMC_addr=0.
  - Reset mid-refill abandons the refill. The memory controller is reset by the same signal.
- Sys_rdy=0: no state, array or output register changes. The memory controller does not pulse MCIC_en while Sys_rdy=0.
- States: IDLE, REFILL.
- IDLE, lookup cycle (IFIC_en=1, gap=0, ROBIC_clear=0):
  - Hit (valid and tag match): next edge ICIF_en=1, ICIF_data=word[IFIC_pc[3:2]], gap=1. Latency is one cycle.
  - Miss: next edge go to REFILL, clear the line's valid bit, counter=0, ICMC_en=1, ICMC_addr={tag,index,4'b0}. No response.
- Gap: on the edge after any response, ICIF_en returns to 0 and gap clears. No lookup happens in the gap cycle. This stops a duplicate response while the fetcher still presents the old pc. Peak rate is one instruction per two cycles.
- ICIF_en is 0 in every cycle that is not a hit-response cycle.
- REFILL:
  - On MCIC_en, write MCIC_data to word[counter] and increment counter.
  - If counter was 3: write tag, set valid, set ICMC_en=0, return to IDLE.
  - Otherwise: ICMC_addr advances by 4 on the same edge and ICMC_en stays 1.
  - Words are fetched in order 0..3, with exactly one request outstanding.
  - The first IDLE cycle after refill performs a fresh lookup of the current IFIC_pc. The original pc normally hits, so miss-to-response = refill time + 1 cycle.
- ROBIC_clear=1 in a cycle:
  - Next edge ICIF_en=0 and gap=0, even if a hit would have responded.
  - In REFILL, the refill runs to completion (the memory request cannot be cancelled) and no response is produced for the old pc. The next lookup uses the redirected IFIC_pc.
- IFIC_pc change during REFILL: ignored until return to IDLE. The line being filled is never served partially.
- IFIC_en=0 in IDLE: no lookup, no memory activity.
- Address arithmetic is modulo 2^ADDR_WIDTH. A line never crosses an index boundary (line-aligned base address).

Test Plan:
- Cold miss, pc=0x0, memory latency 3 cycles/word -> ICMC_addr sequence 0x0,0x4,0x8,0xC, ICMC_en drops after the 4th MCIC_en; one cycle later ICIF_en pulses once with the word at 0x0.
- After that fill, pc=0x8 held high for 5 cycles -> exactly one ICIF_en pulse, 1 cycle after lookup, data = word at 0x8; ICMC_en stays 0; ICIF_data held after the pulse.
- Conflict: fill pc=0x0, then pc=0x1000 (same index 0, different tag) -> refill at 0x1000..0x100C; then pc=0x0 misses again and refills.
- ROBIC_clear asserted in a hit lookup cycle -> ICIF_en stays 0. Clear during REFILL of 0x20 with IFIC_pc switched to 0x40 -> refill of 0x20 completes, no response for 0x20, then refill of 0x40 and a response with word 0x40.
- Sys_rdy=0 for 4 cycles mid-refill -> ICMC_addr, counter and ICIF_en frozen; resuming completes normally.
- Sys_rst low mid-refill, between clock edges -> ICMC_en and ICIF_en go to 0 immediately. After release, pc=0x0 misses even though the line had previously been valid.
